demux1_3_stream: RTL and testbench



---
 rtl/mux_pkg.sv | 31 +++
 rtl/demux_out_slot.sv | 27 ++
 rtl/demux1_3_stream.sv | 86 ++++++++
 tb/tb_demux1_3_stream.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the stream mux/demux family: channel index type,
// channel constants, select decode and the round-robin pointer states.
package mux_pkg;

    typedef logic [1:0] chan_t;

    localparam chan_t CH0 = 2'd0;
    localparam chan_t CH1 = 2'd1;
    localparam chan_t CH2 = 2'd2;

    // Round-robin pointer states; encoding 2'b11 is unused and recovers to RrCh0.
    typedef enum logic [1:0] {
        RrCh0 = 2'd0,
        RrCh1 = 2'd1,
        RrCh2 = 2'd2
    } rr_state_t;

    // Select decode shared with the 3:1 mux: 00 -> ch0, 01 -> ch1, 1x -> ch2.
    function automatic chan_t sel_to_chan(input logic [1:0] sel);
        chan_t chan;
        if (sel[1]) begin
            chan = CH2;
        end else if (sel[0]) begin
            chan = CH1;
        end else begin
            chan = CH0;
        end
        return chan;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel with valid/ready drain.
module demux_out_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Load wins over drain so a word can pass through a draining slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1_3_stream.sv
// 1-to-3 stream demultiplexer with select-code or round-robin routing and an
// independent one-entry output register per channel.
module demux1_3_stream
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rr_en,
    output logic [3*WIDTH-1:0] out_data,
    output logic [2:0]         out_valid,
    input  logic [2:0]         out_ready
);

    rr_state_t rr_state;
    chan_t     rr_ptr;
    chan_t     target;
    logic      in_xfer;
    logic [2:0] load;

    assign in_xfer = in_valid & in_ready;

    // Round-robin pointer: advances only on an accepted word in round-robin mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_state <= RrCh0;
        end else begin
            case (rr_state)
                RrCh0:   if (in_xfer && rr_en) rr_state <= RrCh1;
                RrCh1:   if (in_xfer && rr_en) rr_state <= RrCh2;
                RrCh2:   if (in_xfer && rr_en) rr_state <= RrCh0;
                default: rr_state <= RrCh0;
            endcase
        end
    end

    // Map pointer state to a channel; the unused encoding reads as ch0.
    always_comb begin
        rr_ptr = CH0;
        case (rr_state)
            RrCh1:   rr_ptr = CH1;
            RrCh2:   rr_ptr = CH2;
            default: rr_ptr = CH0;
        endcase
    end

    // Target channel, re-evaluated every cycle so a stalled word may be re-steered.
    always_comb begin
        target = rr_en ? rr_ptr : sel_to_chan(in_sel);
    end

    // Accept when the target slot is empty or draining this cycle.
    always_comb begin
        in_ready = 1'b0;
        case (target)
            CH0:     in_ready = !out_valid[0] | out_ready[0];
            CH1:     in_ready = !out_valid[1] | out_ready[1];
            CH2:     in_ready = !out_valid[2] | out_ready[2];
            default: in_ready = 1'b0;
        endcase
    end

    for (genvar k = 0; k < 3; k++) begin : g_slot
        localparam chan_t Ch = chan_t'(k);

        assign load[k] = in_xfer & (target == Ch);

        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .data     (out_data[k*WIDTH +: WIDTH]),
            .valid    (out_valid[k])
        );
    end

endmodule

// File: tb/tb_demux1_3_stream.sv
// Directed, table-driven bench for demux1_3_stream (WIDTH = 8).
module tb_demux1_3_stream;

    localparam int unsigned WIDTH = 8;
    localparam int NVEC = 25;

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic               rr_en;
    logic [3*WIDTH-1:0] out_data;
    logic [2:0]         out_valid;
    logic [2:0]         out_ready;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  sel;
        logic        v;
        logic        rr;
        logic [2:0]  ordy;
        logic        exp_rdy;
        logic [2:0]  exp_vld;
        logic [23:0] exp_data;  // {ch2, ch1, ch0} after the clock edge
    } vec_t;

    vec_t vecs [NVEC];

    demux1_3_stream #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rr_en    (rr_en),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] sel, input logic v,
                         input logic rr, input logic [2:0] ordy);
        in_data   = d;
        in_sel    = sel;
        in_valid  = v;
        rr_en     = rr;
        out_ready = ordy;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Select routing, rr_en = 0
        vecs[0]  = '{8'hA1, 2'b00, 1'b1, 1'b0, 3'b111, 1'b1, 3'b001, 24'h0000A1};
        vecs[1]  = '{8'hB2, 2'b01, 1'b1, 1'b0, 3'b111, 1'b1, 3'b010, 24'h00B2A1};
        vecs[2]  = '{8'hC3, 2'b10, 1'b1, 1'b0, 3'b111, 1'b1, 3'b100, 24'hC3B2A1};
        vecs[3]  = '{8'hD4, 2'b11, 1'b1, 1'b0, 3'b111, 1'b1, 3'b100, 24'hD4B2A1};
        vecs[4]  = '{8'h00, 2'b00, 1'b0, 1'b0, 3'b111, 1'b1, 3'b000, 24'hD4B2A1};
        // Round-robin 01..06, then 07 proves the pointer wrapped to ch0
        vecs[5]  = '{8'h01, 2'b11, 1'b1, 1'b1, 3'b111, 1'b1, 3'b001, 24'hD4B201};
        vecs[6]  = '{8'h02, 2'b11, 1'b1, 1'b1, 3'b111, 1'b1, 3'b010, 24'hD40201};
        vecs[7]  = '{8'h03, 2'b00, 1'b1, 1'b1, 3'b111, 1'b1, 3'b100, 24'h030201};
        vecs[8]  = '{8'h04, 2'b01, 1'b1, 1'b1, 3'b111, 1'b1, 3'b001, 24'h030204};
        vecs[9]  = '{8'h05, 2'b10, 1'b1, 1'b1, 3'b111, 1'b1, 3'b010, 24'h030504};
        vecs[10] = '{8'h06, 2'b00, 1'b1, 1'b1, 3'b111, 1'b1, 3'b100, 24'h060504};
        vecs[11] = '{8'h07, 2'b10, 1'b1, 1'b1, 3'b111, 1'b1, 3'b001, 24'h060507};
        // Backpressure on ch2 with select routing
        vecs[12] = '{8'h11, 2'b10, 1'b1, 1'b0, 3'b011, 1'b1, 3'b100, 24'h110507};
        vecs[13] = '{8'h22, 2'b10, 1'b1, 1'b0, 3'b011, 1'b0, 3'b100, 24'h110507};
        vecs[14] = '{8'h33, 2'b00, 1'b1, 1'b0, 3'b011, 1'b1, 3'b101, 24'h110533};
        vecs[15] = '{8'h22, 2'b10, 1'b1, 1'b0, 3'b111, 1'b1, 3'b100, 24'h220533};
        // Round-robin stall on ch2: pointer (at ch1) must not advance while stalled
        vecs[16] = '{8'h44, 2'b00, 1'b1, 1'b1, 3'b011, 1'b1, 3'b110, 24'h224433};
        vecs[17] = '{8'h55, 2'b00, 1'b1, 1'b1, 3'b011, 1'b0, 3'b100, 24'h224433};
        vecs[18] = '{8'h55, 2'b00, 1'b1, 1'b1, 3'b111, 1'b1, 3'b100, 24'h554433};
        vecs[19] = '{8'h66, 2'b00, 1'b1, 1'b1, 3'b111, 1'b1, 3'b001, 24'h554466};
        // Pass-through on ch1
        vecs[20] = '{8'h55, 2'b01, 1'b1, 1'b0, 3'b101, 1'b1, 3'b010, 24'h555566};
        vecs[21] = '{8'h66, 2'b01, 1'b1, 1'b0, 3'b111, 1'b1, 3'b010, 24'h556666};
        vecs[22] = '{8'h00, 2'b00, 1'b0, 1'b0, 3'b111, 1'b1, 3'b000, 24'h556666};
        // Pointer held at ch1 across select-mode traffic, then ch0/ch1 loaded for reset test
        vecs[23] = '{8'h88, 2'b00, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 24'h556688};
        vecs[24] = '{8'h77, 2'b00, 1'b1, 1'b1, 3'b000, 1'b1, 3'b011, 24'h557788};

        drive(8'h00, 2'b00, 1'b0, 1'b0, 3'b111);
        rst_n = 1'b0;
        #2;
        check("reset_valid", {21'd0, out_valid}, 24'd0);
        check("reset_data", out_data, 24'd0);
        #10;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", {23'd0, in_ready}, 24'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].d, vecs[i].sel, vecs[i].v, vecs[i].rr, vecs[i].ordy);
            #1;
            check($sformatf("v%0d_in_ready", i), {23'd0, in_ready}, {23'd0, vecs[i].exp_rdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), {21'd0, out_valid}, {21'd0, vecs[i].exp_vld});
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
        end

        // Mid-stream reset: pointer at ch2, ch0/ch1 full
        @(negedge clk);
        drive(8'h00, 2'b00, 1'b0, 1'b1, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {21'd0, out_valid}, 24'd0);
        check("midrst_data", out_data, 24'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", {23'd0, in_ready}, 24'd1);
        @(posedge clk);
        #1;
        check("postrst_no_pulse", {21'd0, out_valid}, 24'd0);
        @(negedge clk);
        drive(8'h99, 2'b10, 1'b1, 1'b1, 3'b000);
        #1;
        check("postrst_rr_ready", {23'd0, in_ready}, 24'd1);
        @(posedge clk);
        #1;
        check("postrst_rr_valid", {21'd0, out_valid}, 24'h000001);
        check("postrst_rr_data", out_data, 24'h000099);

        @(negedge clk);
        drive(8'h00, 2'b00, 1'b0, 1'b0, 3'b111);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
